// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle MIPS control FSM: states, ALU codes,
// opcode/funct constants and datapath mux encodings.
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC_R = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_EXEC_I = 4'd10,
        S_IWB    = 4'd11,
        S_TRAP   = 4'd12
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_SLT = 3'd4;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;

    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_SLT  = 6'b101010;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    localparam logic [1:0] SRCB_B     = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    // States that hold the shared memory port until mem_ready.
    function automatic logic is_req(input state_t s);
        return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
    endfunction

endpackage

// File: rtl/mc_alu_dec.sv
// Combinational op/funct -> ALU operation decode, plus a flag telling the
// dispatcher whether an R-type funct is one we implement.
module mc_alu_dec
    import mc_pkg::*;
(
    input  logic [5:0] i_op,
    input  logic [5:0] i_funct,
    output logic [2:0] o_alu_op,
    output logic       o_rtype_ok
);

    always_comb begin
        o_alu_op   = ALU_ADD;
        o_rtype_ok = 1'b0;
        case (i_op)
            OP_RTYPE: begin
                o_rtype_ok = 1'b1;
                case (i_funct)
                    FN_ADDU: o_alu_op = ALU_ADD;
                    FN_SUBU: o_alu_op = ALU_SUB;
                    FN_AND:  o_alu_op = ALU_AND;
                    FN_OR:   o_alu_op = ALU_OR;
                    FN_SLT:  o_alu_op = ALU_SLT;
                    default: o_rtype_ok = 1'b0;
                endcase
            end
            OP_ORI:  o_alu_op = ALU_OR;
            OP_BEQ:  o_alu_op = ALU_SUB;
            default: o_alu_op = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multicycle MIPS control FSM with a shared req/ready memory port and timeout.
// Define MC_CTRL_PERF_EN to build the retired-instruction counter.
module mc_ctrl
    import mc_pkg::*;
#(
    parameter int WAIT_MAX = 15
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [5:0]  i_op,
    input  logic [5:0]  i_funct,
    input  logic        i_zero,
    input  logic        i_mem_ready,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic        o_iord,
    output logic        o_ir_write,
    output logic        o_pc_write,
    output logic [1:0]  o_pc_src,
    output logic        o_reg_write,
    output logic        o_gpr_sel,
    output logic        o_wd_sel,
    output logic        o_ext_op,
    output logic        o_alu_src_a,
    output logic [1:0]  o_alu_src_b,
    output logic [2:0]  o_alu_op,
    output logic        o_illegal,
    output logic        o_bus_err,
    output logic [3:0]  o_state,
    output logic [31:0] o_instret
);

    localparam logic [15:0] WAIT_LIM = 16'(WAIT_MAX);

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_wait;
    logic        r_illegal;
    logic        r_bus_err;
    logic        w_timeout;
    logic        w_set_illegal;
    logic        w_set_bus_err;
    logic [2:0]  w_dec_alu_op;
    logic        w_rtype_ok;

    mc_alu_dec u_alu_dec (
        .i_op       (i_op),
        .i_funct    (i_funct),
        .o_alu_op   (w_dec_alu_op),
        .o_rtype_ok (w_rtype_ok)
    );

    // This cycle is the WAIT_MAX-th consecutive miss, so give up on the access.
    assign w_timeout = (WAIT_LIM != 16'd0) && !i_mem_ready && ((r_wait + 16'd1) == WAIT_LIM);

    always_comb begin
        w_next        = r_state;
        w_set_illegal = 1'b0;
        w_set_bus_err = 1'b0;
        o_mem_req     = 1'b0;
        o_mem_we      = 1'b0;
        o_iord        = 1'b0;
        o_ir_write    = 1'b0;
        o_pc_write    = 1'b0;
        o_pc_src      = PC_ALU;
        o_reg_write   = 1'b0;
        o_gpr_sel     = 1'b0;
        o_wd_sel      = 1'b0;
        o_ext_op      = 1'b0;
        o_alu_src_a   = 1'b0;
        o_alu_src_b   = SRCB_B;
        o_alu_op      = ALU_ADD;
        case (r_state)
            S_FETCH: begin
                o_mem_req   = 1'b1;
                o_alu_src_b = SRCB_FOUR;
                if (i_mem_ready) begin
                    o_ir_write = 1'b1;
                    o_pc_write = 1'b1;
                    w_next     = S_DECODE;
                end else if (w_timeout) begin
                    w_set_bus_err = 1'b1;
                    w_next        = S_TRAP;
                end
            end
            S_DECODE: begin
                o_alu_src_b = SRCB_IMMSH;
                o_ext_op    = 1'b1;
                case (i_op)
                    OP_RTYPE: begin
                        w_next        = w_rtype_ok ? S_EXEC_R : S_TRAP;
                        w_set_illegal = !w_rtype_ok;
                    end
                    OP_LW, OP_SW:    w_next = S_MEMADR;
                    OP_BEQ:          w_next = S_BRANCH;
                    OP_J:            w_next = S_JUMP;
                    OP_ADDI, OP_ORI: w_next = S_EXEC_I;
                    default: begin
                        w_set_illegal = 1'b1;
                        w_next        = S_TRAP;
                    end
                endcase
            end
            S_EXEC_R: begin
                o_alu_src_a = 1'b1;
                o_alu_op    = w_dec_alu_op;
                w_next      = S_RWB;
            end
            S_RWB: begin
                o_reg_write = 1'b1;
                w_next      = S_FETCH;
            end
            S_EXEC_I: begin
                o_alu_src_a = 1'b1;
                o_alu_src_b = SRCB_IMM;
                o_ext_op    = (i_op == OP_ADDI);
                o_alu_op    = w_dec_alu_op;
                w_next      = S_IWB;
            end
            S_IWB: begin
                o_reg_write = 1'b1;
                o_gpr_sel   = 1'b1;
                w_next      = S_FETCH;
            end
            S_MEMADR: begin
                o_alu_src_a = 1'b1;
                o_alu_src_b = SRCB_IMM;
                o_ext_op    = 1'b1;
                w_next      = (i_op == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD, S_MEMWR: begin
                o_mem_req = 1'b1;
                o_iord    = 1'b1;
                o_mem_we  = (r_state == S_MEMWR);
                if (i_mem_ready) begin
                    w_next = (r_state == S_MEMWR) ? S_FETCH : S_MEMWB;
                end else if (w_timeout) begin
                    w_set_bus_err = 1'b1;
                    w_next        = S_TRAP;
                end
            end
            S_MEMWB: begin
                o_reg_write = 1'b1;
                o_gpr_sel   = 1'b1;
                o_wd_sel    = 1'b1;
                w_next      = S_FETCH;
            end
            S_BRANCH: begin
                o_alu_src_a = 1'b1;
                o_alu_op    = ALU_SUB;
                o_pc_src    = PC_ALUOUT;
                o_pc_write  = i_zero;
                w_next      = S_FETCH;
            end
            S_JUMP: begin
                o_pc_write = 1'b1;
                o_pc_src   = PC_JUMP;
                w_next     = S_FETCH;
            end
            default: w_next = S_TRAP;
        endcase
        // Reset must silence the bus and write enables immediately, not at the next edge.
        if (!i_rst_n) begin
            o_mem_req   = 1'b0;
            o_mem_we    = 1'b0;
            o_ir_write  = 1'b0;
            o_pc_write  = 1'b0;
            o_reg_write = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= S_FETCH;
            r_wait    <= 16'd0;
            r_illegal <= 1'b0;
            r_bus_err <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_next != r_state) begin
                r_wait <= 16'd0;
            end else if (is_req(r_state) && !i_mem_ready && (r_wait != 16'hFFFF)) begin
                r_wait <= r_wait + 16'd1;
            end
            if (w_set_illegal) r_illegal <= 1'b1;
            if (w_set_bus_err) r_bus_err <= 1'b1;
        end
    end

    assign o_illegal = r_illegal;
    assign o_bus_err = r_bus_err;
    assign o_state   = r_state;

`ifdef MC_CTRL_PERF_EN
    logic [31:0] r_instret;
    logic        w_retire;

    assign w_retire = (w_next == S_FETCH) &&
                      (r_state inside {S_RWB, S_IWB, S_MEMWB, S_MEMWR, S_BRANCH, S_JUMP});

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_instret <= 32'd0;
        end else if (w_retire) begin
            r_instret <= r_instret + 32'd1;
        end
    end

    assign o_instret = r_instret;
`else
    assign o_instret = 32'd0;
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl (WAIT_MAX=4): walks each instruction class
// through its state sequence and checks control outputs per cycle.
module tb_mc_ctrl;

    logic        clk = 1'b0;
    logic        rstN = 1'b0;
    logic [5:0]  op = 6'd0;
    logic [5:0]  funct = 6'd0;
    logic        zero = 1'b0;
    logic        memReady = 1'b0;

    logic        memReq, memWe, iord, irWrite, pcWrite;
    logic [1:0]  pcSrc;
    logic        regWrite, gprSel, wdSel, extOp, aluSrcA;
    logic [1:0]  aluSrcB;
    logic [2:0]  aluOp;
    logic        illegal, busErr;
    logic [3:0]  state;
    logic [31:0] instret;

    int errors = 0;
    int checks = 0;
    int retired = 0;

    localparam logic [5:0] LW = 6'b100011;
    localparam logic [5:0] SW = 6'b101011;

    logic [5:0] rFunct [4] = '{6'b100011, 6'b100100, 6'b100101, 6'b101010};
    logic [2:0] rAluOp [4] = '{3'd1, 3'd2, 3'd3, 3'd4};
    logic [5:0] iOp    [2] = '{6'b001101, 6'b001000};
    logic [3:0] iExp   [2] = '{{1'b0, 3'd3}, {1'b1, 3'd0}};

    always #5 clk = ~clk;

    mc_ctrl #(.WAIT_MAX(4)) dut (
        .i_clk       (clk),
        .i_rst_n     (rstN),
        .i_op        (op),
        .i_funct     (funct),
        .i_zero      (zero),
        .i_mem_ready (memReady),
        .o_mem_req   (memReq),
        .o_mem_we    (memWe),
        .o_iord      (iord),
        .o_ir_write  (irWrite),
        .o_pc_write  (pcWrite),
        .o_pc_src    (pcSrc),
        .o_reg_write (regWrite),
        .o_gpr_sel   (gprSel),
        .o_wd_sel    (wdSel),
        .o_ext_op    (extOp),
        .o_alu_src_a (aluSrcA),
        .o_alu_src_b (aluSrcB),
        .o_alu_op    (aluOp),
        .o_illegal   (illegal),
        .o_bus_err   (busErr),
        .o_state     (state),
        .o_instret   (instret)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [5:0] nOp, input logic [5:0] nFunct, input logic nZero, input logic nReady);
        @(negedge clk);
        op       = nOp;
        funct    = nFunct;
        zero     = nZero;
        memReady = nReady;
        #1;
    endtask

    function automatic logic [31:0] expInstret();
`ifdef MC_CTRL_PERF_EN
        return 32'(retired);
`else
        return 32'd0;
`endif
    endfunction

    task automatic resetPulse(input string tag);
        rstN     = 1'b0;
        memReady = 1'b0;
        #1;
        checkOutput({tag, " reset state"}, 32'(state), 32'd0);
        checkOutput({tag, " reset req/flags"}, {memReq, illegal, busErr}, 3'b000);
        retired = 0;
        @(negedge clk);
        rstN = 1'b1;
    endtask

    initial begin
        $display("[TB] mc_ctrl directed test start");
        #2;
        checkOutput("reset state", 32'(state), 32'd0);
        checkOutput("reset enables", {memReq, memWe, irWrite, pcWrite, regWrite}, 5'b0);
        checkOutput("reset flags", {illegal, busErr}, 2'b00);
        checkOutput("reset instret", instret, 32'd0);
        @(negedge clk);
        rstN = 1'b1;

        // addu with no wait states: 0,1,6,7
        applyStimulus(6'b000000, 6'b100001, 1'b0, 1'b1);
        checkOutput("addu fetch state", 32'(state), 32'd0);
        checkOutput("addu fetch ctrl", {memReq, iord, irWrite, pcWrite, pcSrc, aluSrcA, aluSrcB, aluOp},
                    {1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 2'b01, 3'd0});
        applyStimulus(6'b000000, 6'b100001, 1'b0, 1'b1);
        checkOutput("addu decode state", 32'(state), 32'd1);
        checkOutput("addu decode ctrl", {aluSrcA, aluSrcB, aluOp, extOp, regWrite}, {1'b0, 2'b11, 3'd0, 1'b1, 1'b0});
        applyStimulus(6'b000000, 6'b100001, 1'b0, 1'b1);
        checkOutput("addu exec state", 32'(state), 32'd6);
        checkOutput("addu exec ctrl", {aluSrcA, aluSrcB, aluOp, regWrite}, {1'b1, 2'b00, 3'd0, 1'b0});
        applyStimulus(6'b000000, 6'b100001, 1'b0, 1'b1);
        checkOutput("addu rwb state", 32'(state), 32'd7);
        checkOutput("addu rwb ctrl", {regWrite, gprSel, wdSel, memReq}, 4'b1000);
        retired++;

        // lw with three wait cycles in FETCH and in MEMRD: 11 cycles total
        for (int w = 0; w < 3; w++) begin
            applyStimulus(LW, 6'd0, 1'b0, 1'b0);
            checkOutput("lw fetch wait state", 32'(state), 32'd0);
            checkOutput("lw fetch wait ctrl", {memReq, memWe, iord, irWrite, pcWrite}, 5'b10000);
            if (w == 0) checkOutput("addu instret", instret, expInstret());
        end
        applyStimulus(LW, 6'd0, 1'b0, 1'b1);
        checkOutput("lw fetch ready ctrl", {state, memReq, memWe, iord, irWrite, pcWrite}, {4'd0, 5'b10011});
        applyStimulus(LW, 6'd0, 1'b0, 1'b0);
        checkOutput("lw decode state", 32'(state), 32'd1);
        applyStimulus(LW, 6'd0, 1'b0, 1'b0);
        checkOutput("lw memadr ctrl", {state, aluSrcA, aluSrcB, extOp, aluOp, memReq}, {4'd2, 1'b1, 2'b10, 1'b1, 3'd0, 1'b0});
        for (int w = 0; w < 4; w++) begin
            applyStimulus(LW, 6'd0, 1'b0, (w == 3));
            checkOutput("lw memrd ctrl", {state, memReq, memWe, iord, regWrite}, {4'd3, 4'b1010});
        end
        applyStimulus(LW, 6'd0, 1'b0, 1'b0);
        checkOutput("lw memwb ctrl", {state, regWrite, gprSel, wdSel}, {4'd4, 3'b111});
        retired++;

        // remaining R-type functs
        for (int i = 0; i < 4; i++) begin
            applyStimulus(6'b000000, rFunct[i], 1'b0, 1'b1);
            checkOutput("rtype fetch state", 32'(state), 32'd0);
            if (i == 0) checkOutput("lw instret", instret, expInstret());
            applyStimulus(6'b000000, rFunct[i], 1'b0, 1'b1);
            applyStimulus(6'b000000, rFunct[i], 1'b0, 1'b1);
            checkOutput("rtype exec aluop", {state, aluOp}, {4'd6, rAluOp[i]});
            applyStimulus(6'b000000, rFunct[i], 1'b0, 1'b1);
            checkOutput("rtype rwb state", 32'(state), 32'd7);
            retired++;
        end

        // beq not taken then taken
        for (int z = 0; z < 2; z++) begin
            applyStimulus(6'b000100, 6'd0, 1'(z), 1'b1);
            checkOutput("beq fetch state", 32'(state), 32'd0);
            applyStimulus(6'b000100, 6'd0, 1'(z), 1'b1);
            checkOutput("beq decode state", 32'(state), 32'd1);
            applyStimulus(6'b000100, 6'd0, 1'(z), 1'b1);
            checkOutput("beq branch ctrl", {state, pcWrite, pcSrc, aluSrcA, aluSrcB, aluOp},
                        {4'd8, 1'(z), 2'b01, 1'b1, 2'b00, 3'd1});
            retired++;
        end

        // j
        applyStimulus(6'b000010, 6'd0, 1'b0, 1'b1);
        checkOutput("beq instret", instret, expInstret());
        applyStimulus(6'b000010, 6'd0, 1'b0, 1'b1);
        applyStimulus(6'b000010, 6'd0, 1'b0, 1'b1);
        checkOutput("j jump ctrl", {state, pcWrite, pcSrc, regWrite}, {4'd9, 1'b1, 2'b10, 1'b0});
        retired++;

        // ori then addi
        for (int i = 0; i < 2; i++) begin
            applyStimulus(iOp[i], 6'd0, 1'b0, 1'b1);
            checkOutput("itype fetch state", 32'(state), 32'd0);
            applyStimulus(iOp[i], 6'd0, 1'b0, 1'b1);
            applyStimulus(iOp[i], 6'd0, 1'b0, 1'b1);
            checkOutput("itype exec ctrl", {state, aluSrcA, aluSrcB, extOp, aluOp}, {4'd10, 1'b1, 2'b10, iExp[i]});
            applyStimulus(iOp[i], 6'd0, 1'b0, 1'b1);
            checkOutput("itype iwb ctrl", {state, regWrite, gprSel, wdSel}, {4'd11, 3'b110});
            retired++;
        end

        // unsupported opcode traps and stays dead for 20 cycles
        applyStimulus(6'b111111, 6'd0, 1'b0, 1'b1);
        checkOutput("itype instret", instret, expInstret());
        applyStimulus(6'b111111, 6'd0, 1'b0, 1'b1);
        checkOutput("illegal decode state", 32'(state), 32'd1);
        for (int c = 0; c < 20; c++) begin
            applyStimulus(6'b111111, 6'd0, 1'(c), 1'b1);
            checkOutput("illegal trap hold", {state, memReq, memWe, irWrite, pcWrite, regWrite, illegal, busErr},
                        {4'd12, 5'b00000, 1'b1, 1'b0});
        end
        resetPulse("illegal op");

        // unsupported R-type funct also traps
        applyStimulus(6'b000000, 6'b000000, 1'b0, 1'b1);
        checkOutput("bad funct fetch", {state, instret}, {4'd0, 32'd0});
        applyStimulus(6'b000000, 6'b000000, 1'b0, 1'b1);
        applyStimulus(6'b000000, 6'b000000, 1'b0, 1'b1);
        checkOutput("bad funct trap", {state, illegal}, {4'd12, 1'b1});
        resetPulse("bad funct");

        // sw with mem_ready never asserted: TRAP after 4 waits
        applyStimulus(SW, 6'd0, 1'b0, 1'b1);
        applyStimulus(SW, 6'd0, 1'b0, 1'b1);
        applyStimulus(SW, 6'd0, 1'b0, 1'b1);
        checkOutput("sw memadr state", 32'(state), 32'd2);
        for (int w = 0; w < 4; w++) begin
            applyStimulus(SW, 6'd0, 1'b0, 1'b0);
            checkOutput("sw timeout wait ctrl", {state, memReq, memWe, iord, busErr}, {4'd5, 3'b111, 1'b0});
        end
        applyStimulus(SW, 6'd0, 1'b0, 1'b0);
        checkOutput("sw timeout trap", {state, busErr, illegal, memReq}, {4'd12, 1'b1, 1'b0, 1'b0});
        resetPulse("bus err");

        // sw with mem_ready on the 4th wait cycle completes
        applyStimulus(SW, 6'd0, 1'b0, 1'b1);
        applyStimulus(SW, 6'd0, 1'b0, 1'b1);
        applyStimulus(SW, 6'd0, 1'b0, 1'b1);
        for (int w = 0; w < 4; w++) begin
            applyStimulus(SW, 6'd0, 1'b0, (w == 3));
            checkOutput("sw late ready ctrl", {state, memReq, memWe, iord}, {4'd5, 3'b111});
        end
        retired++;

        // reset during a MEMWR wait drops mem_req at once
        applyStimulus(SW, 6'd0, 1'b0, 1'b1);
        checkOutput("sw late ready no trap", {state, busErr}, {4'd0, 1'b0});
        checkOutput("sw instret", instret, expInstret());
        applyStimulus(SW, 6'd0, 1'b0, 1'b1);
        applyStimulus(SW, 6'd0, 1'b0, 1'b1);
        applyStimulus(SW, 6'd0, 1'b0, 1'b0);
        applyStimulus(SW, 6'd0, 1'b0, 1'b0);
        checkOutput("sw before reset", {state, memReq}, {4'd5, 1'b1});
        rstN = 1'b0;
        #1;
        checkOutput("async reset mem_req", {memReq, memWe, state}, {2'b00, 4'd0});
        retired = 0;
        @(negedge clk);
        rstN = 1'b1;
        applyStimulus(6'd0, 6'd0, 1'b0, 1'b0);
        checkOutput("after reset fetch", {state, memReq, instret}, {4'd0, 1'b1, expInstret()});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
- Multicycle control FSM that sequences the existing MIPS datapath blocks (PC, RF, ALU, EXT, muxes) over several cycles instead of one.
- Adds a single shared instruction/data memory port with a req/ready handshake, so fetch and load/store take variable wait states.
- Sits beside the datapath inside the multicycle CPU top and drives every mux select and write enable.

Parameters:
- WAIT_MAX, 15, maximum cycles mem_req may wait for mem_ready before a bus-error trap; 0 disables the timeout.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- op  in  6  instr[31:26] from the instruction register
- funct  in  6  instr[5:0] from the instruction register
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current access this cycle
- mem_req  out  1  memory access request
- mem_we  out  1  write qualifier, valid with mem_req
- iord  out  1  address select: 0 = PC, 1 = ALUOut register
- ir_write  out  1  load the instruction register
- pc_write  out  1  load the PC
- pc_src  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target
- reg_write  out  1  RF write enable
- gpr_sel  out  1  RF write address: 0 = rd, 1 = rt
- wd_sel  out  1  RF write data: 0 = ALUOut, 1 = MDR
- ext_op  out  1  1 = sign extension, 0 = zero extension
- alu_src_a  out  1  0 = PC, 1 = A register
- alu_src_b  out  2  00 = B register, 01 = constant 4, 10 = Imm32, 11 = Imm32<<2
- alu_op  out  3  ALU operation code (package constant)
- illegal  out  1  sticky: unsupported opcode or funct trapped
- bus_err  out  1  sticky: memory timeout trapped
- state  out  4  current state encoding, for debug
- instret  out  32  retired-instruction count (see Optional Feature)

Behaviour:
- Reset (rst=0, asynchronous): state=FETCH; all enables 0; illegal=bus_err=0; wait counter=0; instret=0.
- All outputs are a Moore/Mealy decode of state. The only Mealy terms are mem_ready and zero.
- FETCH (0):
  - Drives mem_req=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=ADD.
  - While mem_ready=0, stays in FETCH and counts waits.
  - On mem_ready=1: ir_write=1, pc_write=1, pc_src=00; next state DECODE.
- DECODE (1): alu_src_a=0, alu_src_b=11, alu_op=ADD, ext_op=1, so the branch target lands in ALUOut. Dispatch:
  - op 000000 with a supported funct -> EXEC_R.
  - lw 100011 or sw 101011 -> MEMADR.
  - beq 000100 -> BRANCH.
  - j 000010 -> JUMP.
  - addi 001000 or ori 001101 -> EXEC_I.
  - Anything else -> TRAP with illegal=1.
- Supported R-type funct codes: addu 100001, subu 100011, and 100100, or 100101, slt 101010. Any other funct goes to TRAP.
- EXEC_R (6): alu_src_a=1, alu_src_b=00, alu_op from funct -> RWB (7).
- RWB (7): reg_write=1, gpr_sel=0, wd_sel=0 -> FETCH.
- EXEC_I (10): alu_src_a=1, alu_src_b=10; addi uses ext_op=1 and ADD; ori uses ext_op=0 and OR -> IWB (11).
- IWB (11): reg_write=1, gpr_sel=1, wd_sel=0 -> FETCH.
- MEMADR (2): alu_src_a=1, alu_src_b=10, ext_op=1, ADD. Next state MEMRD for lw, MEMWR for sw.
- MEMRD (3): mem_req=1, iord=1, mem_we=0; holds until mem_ready -> MEMWB (4).
- MEMWB (4): reg_write=1, gpr_sel=1, wd_sel=1 -> FETCH.
- MEMWR (5): mem_req=1, mem_we=1, iord=1; holds until mem_ready -> FETCH.
- BRANCH (8): alu_src_a=1, alu_src_b=00, SUB, pc_src=01, pc_write=zero -> FETCH.
- JUMP (9): pc_write=1, pc_src=10 -> FETCH.
- TRAP (12): every enable is 0. The state is terminal until reset; illegal and bus_err are held.
- Handshake:
  - mem_req, mem_we and iord are stable from the first request cycle until the mem_ready cycle, inclusive.
  - mem_ready outside a request state is ignored.
- Timeout:
  - The wait counter clears on entry to any request state and increments each cycle mem_ready=0.
  - When the count reaches WAIT_MAX with mem_ready still 0, the next state is TRAP with bus_err=1.
  - If mem_ready=1 arrives on that same cycle, the access completes and there is no trap.
- An instruction retires on the transition into FETCH from RWB, IWB, MEMWB, MEMWR, BRANCH or JUMP.
- Latencies with zero wait states: R/I-type 4 cycles, lw 5, sw 4, beq 3, j 3.
- Reset asserted mid-access drops mem_req asynchronously.

Optional Feature:
- MC_CTRL_PERF_EN defined: instret increments by 1 on each retire and wraps modulo 2^32.
- Undefined: instret is tied to 0 and the counter logic is absent. The port list is identical in both builds.

Decomposition:
- Package mc_pkg holds:
  - State encodings.
  - ALU codes: ADD=0, SUB=1, AND=2, OR=3, SLT=4.
  - Opcode and funct constants.
  - pc_src and alu_src_b encodings.
- Sub-module mc_alu_dec: combinational funct/op -> alu_op plus an rtype_ok flag. It is shared by DECODE dispatch and EXEC_R.

Test Plan:
- addu (op 000000, funct 100001), mem_ready=1 immediately -> states 0,1,6,7,0; reg_write=1 only in RWB with gpr_sel=0; instret=1.
- lw with mem_ready delayed 3 cycles in both FETCH and MEMRD -> mem_req, iord and mem_we held stable; total 11 cycles; MEMWB has wd_sel=1.
- beq with zero=0, then zero=1 -> pc_write=0, then 1 in BRANCH with pc_src=01; each takes 3 cycles.
- op 111111 -> TRAP, illegal=1, enables stay 0 for 20 cycles; rst=0 pulse returns to FETCH and clears illegal.
- WAIT_MAX=4, sw with mem_ready never asserted -> TRAP after 4 wait cycles with bus_err=1; repeat with mem_ready on wait 4 -> no trap.
- rst asserted during a MEMWR wait -> mem_req=0 in the same cycle; state=0 after release.
